// File: rtl/johnson_pkg.sv
// Shared types and helpers for the Johnson-code decoder.
package johnson_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } lock_state_t;

  function automatic int idx_width(input int n);
    return (2 * n > 1) ? $clog2(2 * n) : 1;
  endfunction

  function automatic int succ(input int idx, input int n);
    return (idx + 1) % (2 * n);
  endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational Johnson-word decoder: legality flag and phase index.
module johnson_code_decode
  import johnson_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  code,
  output logic          legal,
  output logic [IW-1:0] index
);

  // A legal Johnson word has at most one bit transition reading MSB to LSB.
  always_comb begin
    int pop;
    int trans;
    pop   = 0;
    trans = 0;
    for (int i = 0; i < N; i++) begin
      pop = pop + (code[i] ? 1 : 0);
    end
    for (int i = 0; i < N - 1; i++) begin
      if (code[i] != code[i+1]) trans = trans + 1;
    end
    legal = (trans <= 1);
    index = '0;
    if (legal) begin
      if (code[N-1])    index = IW'(pop);
      else if (pop > 0) index = IW'(2 * N - pop);
    end
  end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson-stream decoder with sequence checking and lock FSM.
// Optional saturating error counter enabled by JOHNSON_DECODER_ERRCNT_EN.
//
// state  | meaning
// HUNT   | waiting for any legal word to seed the expected phase
// CHECK  | counting consecutive in-sequence words toward lock
// LOCKED | stream tracks a counter stepping once per valid beat
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter  int N         = 4,
  parameter  int LOCK_GOOD = 4,
  parameter  int CW        = 8,
  localparam int IW        = idx_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [N-1:0]  in_code,
  output logic          out_valid,
  output logic [IW-1:0] out_index,
  output logic          code_err,
  output logic          seq_err,
  output logic          locked,
  output logic [CW-1:0] err_count
);

  localparam int GW = $clog2(LOCK_GOOD + 1);

  lock_state_t   state, state_nxt;
  logic [IW-1:0] prev_idx, prev_nxt;
  logic [GW-1:0] good, good_nxt, good_inc;
  logic [IW-1:0] idx_nxt;
  logic          cerr_nxt, serr_nxt;
  logic          dec_legal, is_succ;
  logic [IW-1:0] dec_index;

  johnson_code_decode #(.N(N)) u_decode (
    .code  (in_code),
    .legal (dec_legal),
    .index (dec_index)
  );

  assign is_succ  = (dec_index == IW'(succ(int'(prev_idx), N)));
  assign good_inc = good + 1'b1;

  always_comb begin
    state_nxt = state;
    prev_nxt  = prev_idx;
    good_nxt  = good;
    idx_nxt   = out_index;
    cerr_nxt  = 1'b0;
    serr_nxt  = 1'b0;
    if (in_valid) begin
      idx_nxt = dec_legal ? dec_index : '0;
      if (!dec_legal) begin
        cerr_nxt  = 1'b1;
        state_nxt = HUNT;
      end else begin
        prev_nxt = dec_index;
        case (state)
          HUNT: begin
            good_nxt  = '0;
            state_nxt = CHECK;
          end
          CHECK: begin
            if (is_succ) begin
              good_nxt = good_inc;
              if (int'(good_inc) >= LOCK_GOOD) state_nxt = LOCKED;
            end else begin
              serr_nxt = 1'b1;
              good_nxt = '0;
            end
          end
          LOCKED: begin
            if (!is_succ) begin
              serr_nxt  = 1'b1;
              state_nxt = HUNT;
            end
          end
          default: state_nxt = HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      prev_idx  <= '0;
      good      <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      code_err  <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      prev_idx  <= prev_nxt;
      good      <= good_nxt;
      out_valid <= in_valid;
      out_index <= idx_nxt;
      code_err  <= cerr_nxt;
      seq_err   <= serr_nxt;
    end
  end

  assign locked = (state == LOCKED);

`ifdef JOHNSON_DECODER_ERRCNT_EN
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if ((cerr_nxt || serr_nxt) && (cnt != {CW{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign err_count = cnt;
`else
  assign err_count = '0;
`endif

endmodule
